fib_stream_checker: RTL and testbench
=====================================

Name: fib_stream_checker

Overview:
- Downstream consumer/monitor for the Fibonacci sequence generator.
- Samples the generator's `out` word whenever `in_valid` is high and checks that each sample continues the sequence 1, 1, 2, 3, 5, … modulo 2^DATA_WIDTH.
- Reports per-term match pulses, a sticky first-error record, a sticky wrap (overflow) flag and a term count.
- Sits beside the generator in the top level; the generator's synchronous restart is mirrored onto `clear`.

Parameters:
- DATA_WIDTH, 32, width of the checked data word; must equal the generator's DATA_WIDTH.
- CNT_WIDTH, 16, width of the term counter and of the error index.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- resetn  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart of the checker; tie to ~generator resetn.
- in_valid  input  1  in_data is a sequence term this cycle.
- in_data  input  DATA_WIDTH  term from the generator's out.
- match  output  1  one-cycle pulse: the last accepted term was correct.
- error  output  1  sticky: a mismatch has occurred since reset/clear.
- err_index  output  CNT_WIDTH  term index (0-based) of the first mismatch.
- err_expected  output  DATA_WIDTH  value expected at the first mismatch.
- overflow  output  1  sticky: some expected term wrapped past 2^DATA_WIDTH.
- term_count  output  CNT_WIDTH  number of correctly matched terms; saturates at all-ones.
- busy  output  1  high in states GOT1 and RUN.

Behaviour:
- Async reset (resetn=0) takes effect immediately, regardless of clk.
  - State goes to IDLE.
  - The prev and cur history registers clear to 0.
  - match, error, overflow and busy go to 0; err_index, err_expected and term_count go to 0.
- All outputs are registered. A response appears in the cycle after the accepting edge, i.e. 1-cycle latency.
- State IDLE: expected value = 1.
  - Valid sample == 1: go to GOT1, cur <= 1, prev <= 0.
  - Valid sample != 1: go to ERR.
- State GOT1: expected value = 1.
  - Valid sample == 1: go to RUN, prev <= 1, cur <= 1.
  - Otherwise: go to ERR.
- State RUN: expected value = (prev + cur) computed at DATA_WIDTH+1 bits; the compare uses the low DATA_WIDTH bits.
  - On match: prev <= cur, cur <= in_data.
  - If the carry bit is 1 on an accepted match, set overflow (sticky). Checking continues, modulo 2^W.
  - On mismatch: go to ERR.
- State ERR: terminal until reset or clear.
  - in_valid is ignored; match never pulses.
  - term_count and the err_* outputs hold.
- On every match in IDLE, GOT1 or RUN:
  - match = 1 for exactly one cycle.
  - term_count increments, saturating at 2^CNT_WIDTH-1 (no wrap).
- On mismatch (the IDLE/GOT1/RUN to ERR transition):
  - error <= 1.
  - err_index <= term_count, which equals the index of the offending term.
  - err_expected <= the expected value.
  - match stays 0.
- Cycles with in_valid = 0: no state change; match = 0; sequence history is preserved. Gaps of any length are allowed.
- clear = 1 (synchronous): same effect as reset at the next edge.
  - clear overrides a simultaneous in_valid; that sample is dropped and not checked.
- The checker holds no assumption of continuous valid and needs no backpressure; it is always ready.
- Async reset asserted mid-sequence: everything clears immediately.
  - After release, the first valid sample is checked as term 0 (expected 1).

Test Plan:
- Run every scenario with DATA_WIDTH=8 and CNT_WIDTH=4.
- Correct run: valid every cycle with 1,1,2,3,5,8,13 -> 7 match pulses, term_count=7, error=0, overflow=0, busy=1 from the cycle after the first term.
- Corrupted term: 1,1,2,4 -> match pulses for the first 3 terms only; error=1, err_index=3, err_expected=3, term_count=3. A subsequent 5,8 gives no match and all outputs hold.
- Bad first term / gaps: a first sample of 0 -> error=1, err_index=0, err_expected=1. After clear, send 1,_,_,1,_,2 (underscore = in_valid low) -> 3 matches, no error.
- Wrap: feed 1,1,…,144,233 then 121 (the low 8 bits of 377) -> the 121 term matches and overflow=1 thereafter. The following 98 (233+121 mod 256) also matches.
- Saturation: 16 correct terms -> term_count stays at 15 with no wrap; match still pulses on every term.
- Reset/clear: assert resetn=0 between clock edges mid-run -> all outputs read 0 before the next edge. Assert clear=1 together with in_valid=1 and data=1 -> state IDLE, term_count=0, no match pulse.

Source files
------------

// File: rtl/fib_stream_checker.sv
// Fibonacci stream checker: verifies sampled terms follow 1,1,2,3,5,... mod 2^DATA_WIDTH,
// recording match pulses, the first mismatch, a sticky wrap flag and a saturating term count.
module fib_stream_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  match,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  err_index,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  term_count,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, GOT1, RUN, ERR} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] prev, cur, prev_nx, cur_nx;
    logic [DATA_WIDTH-1:0] exp_val;
    logic [DATA_WIDTH:0]   sum;
    logic                  take, hit;

    always_comb begin
        sum      = {1'b0, prev} + {1'b0, cur};
        exp_val  = (state == RUN) ? sum[DATA_WIDTH-1:0] : DATA_WIDTH'(1);
        take     = in_valid && (state != ERR);
        hit      = take && (in_data == exp_val);
        state_nx = state;
        prev_nx  = prev;
        cur_nx   = cur;
        if (take) begin
            if (!hit) begin
                state_nx = ERR;
            end else begin
                unique case (state)
                    IDLE: begin
                        state_nx = GOT1;
                        prev_nx  = '0;
                        cur_nx   = DATA_WIDTH'(1);
                    end
                    GOT1: begin
                        state_nx = RUN;
                        prev_nx  = DATA_WIDTH'(1);
                        cur_nx   = DATA_WIDTH'(1);
                    end
                    RUN: begin
                        prev_nx = cur;
                        cur_nx  = in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            prev         <= '0;
            cur          <= '0;
            match        <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            overflow     <= 1'b0;
            term_count   <= '0;
        end else if (clear) begin
            // restart drops any sample presented in the same cycle
            state        <= IDLE;
            prev         <= '0;
            cur          <= '0;
            match        <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            overflow     <= 1'b0;
            term_count   <= '0;
        end else begin
            state <= state_nx;
            prev  <= prev_nx;
            cur   <= cur_nx;
            match <= hit;
            if (hit && (term_count != '1))
                term_count <= term_count + 1'b1;
            if (hit && (state == RUN) && sum[DATA_WIDTH])
                overflow <= 1'b1;
            if (take && !hit) begin
                error        <= 1'b1;
                err_index    <= term_count;
                err_expected <= exp_val;
            end
        end
    end

    assign busy = (state == GOT1) || (state == RUN);

endmodule

// File: tb/tb_fib_stream_checker.sv
// Randomized + directed bench for fib_stream_checker (8-bit data, 4-bit counters);
// a Fibonacci-index reference model feeds a scoreboard drained by a negedge monitor.
module tb_fib_stream_checker;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          match, error, overflow, busy;
    logic [CW-1:0] err_index, term_count;
    logic [DW-1:0] err_expected;

    fib_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .match(match), .error(error), .err_index(err_index), .err_expected(err_expected),
        .overflow(overflow), .term_count(term_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          match;
        logic          error;
        logic [CW-1:0] err_index;
        logic [DW-1:0] err_expected;
        logic          overflow;
        logic [CW-1:0] term_count;
        logic          busy;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    passed = 0;

    // reference model: n = number of correct terms accepted since reset/clear
    int       n;
    bit       m_err, m_ovf, m_match;
    int       m_eidx;
    int       m_eexp;

    function automatic longint fib(input int k);
        longint a = 1, b = 1, t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        n = 0; m_err = 0; m_ovf = 0; m_match = 0; m_eidx = 0; m_eexp = 0;
    endtask

    task automatic model_update(input logic v, input logic [DW-1:0] d, input logic c);
        int e;
        m_match = 0;
        if (c) begin
            model_reset();
        end else if (v && !m_err) begin
            e = int'(fib(n) % 256);
            if (int'(d) == e) begin
                m_match = 1;
                if (fib(n) >= 256) m_ovf = 1;
                n++;
            end else begin
                m_err  = 1;
                m_eidx = sat(n);
                m_eexp = e;
            end
        end
    endtask

    function automatic resp_t model_resp();
        resp_t r;
        r.match        = m_match;
        r.error        = m_err;
        r.err_index    = CW'(m_eidx);
        r.err_expected = DW'(m_eexp);
        r.overflow     = m_ovf;
        r.term_count   = CW'(sat(n));
        r.busy         = !m_err && (n >= 1);
        return r;
    endfunction

    function automatic resp_t dut_resp();
        resp_t r;
        r = {match, error, err_index, err_expected, overflow, term_count, busy};
        return r;
    endfunction

    task automatic compare(input string name, input resp_t act, input resp_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got m=%b e=%b ei=%0d ee=%0d ov=%b tc=%0d b=%b, want m=%b e=%b ei=%0d ee=%0d ov=%b tc=%0d b=%b",
                      name, act.match, act.error, act.err_index, act.err_expected, act.overflow, act.term_count, act.busy,
                      exp.match, exp.error, exp.err_index, exp.err_expected, exp.overflow, exp.term_count, exp.busy);
    endtask

    // monitor: one registered response per stimulated edge
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare("cycle", dut_resp(), e);
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        model_update(v, d, c);
        sb.push_back(model_resp());
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic feed_fib(input int first, input int count);
        for (int i = first; i < first + count; i++) step(1'b1, DW'(fib(i) % 256), 1'b0);
    endtask

    initial begin
        resp_t zero;
        int v, c;
        logic [DW-1:0] d;
        zero = '0;
        model_reset();
        #12;
        compare("reset_state", dut_resp(), zero);
        @(negedge clk);
        resetn = 1'b1;

        // correct run 1,1,2,3,5,8,13
        feed_fib(0, 7);
        step(1'b0, '0, 1'b0);

        // corrupted fourth term, then 5,8 ignored
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'd1, 1'b0); step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd2, 1'b0); step(1'b1, 8'd4, 1'b0);
        step(1'b1, 8'd5, 1'b0); step(1'b1, 8'd8, 1'b0);

        // bad first term, then gapped restart 1,_,_,1,_,2
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'd0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'd1, 1'b0); step(1'b0, '0, 1'b0); step(1'b0, '0, 1'b0);
        step(1'b1, 8'd1, 1'b0); step(1'b0, '0, 1'b0); step(1'b1, 8'd2, 1'b0);

        // wrap through 233 -> 121 -> 98, plus saturation past 16 terms
        step(1'b0, '0, 1'b1);
        feed_fib(0, 18);

        // clear beats a simultaneous valid term
        step(1'b1, 8'd1, 1'b1);
        step(1'b0, '0, 1'b0);

        // async reset between edges mid-run
        feed_fib(0, 4);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1 compare("async_reset", dut_resp(), zero);
        model_reset();
        @(posedge clk);
        #2 compare("reset_held", dut_resp(), zero);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        feed_fib(0, 3);

        // randomized stream with occasional corruption, gaps and clears
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7) ? 1 : 0;
            c = ($urandom_range(0, 39) == 0 || n > 40 || (m_err && $urandom_range(0, 7) == 0)) ? 1 : 0;
            d = DW'(fib(n) % 256);
            if ($urandom_range(0, 24) == 0) d = DW'($urandom_range(0, 255));
            step(v[0], d, c[0]);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
